// File: rtl/cam_capture_core.sv
// Byte-stream camera capture: frames/lines from VSYNC/HREF, assembles RGB565 pixels
// from RGB565, YUYV-luma or raw8 input, with optional 2x2 decimation and error flags.
module cam_capture_core #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CamVsync,
   input  logic          CamHsync,
   input  logic [7:0]    CamData,
   input  logic [1:0]    Mode,
   input  logic          Decim,
   output logic          PixValid,
   output logic [15:0]   PixData,
   output logic [XW-1:0] PixX,
   output logic [YW-1:0] PixY,
   output logic          FrameStart,
   output logic          LineEnd,
   output logic          FrameDone,
   output logic [7:0]    FrameCnt,
   output logic [1:0]    Err
);

   localparam logic [XW:0] H_LIM = (XW+1)'(H_ACTIVE);
   localparam logic [YW:0] V_LIM = (YW+1)'(V_ACTIVE);

   typedef enum logic [1:0] {SYNC = 2'd0, WAIT_LINE = 2'd1, ACTIVE = 2'd2} state_t;
   state_t state, state_nxt;

   logic        vsync_p0;
   logic [1:0]  mode_p0;
   logic        decim_p0;
   logic        phase_p0;
   logic [7:0]  hold_p0;
   logic [XW:0] col_p0;
   logic [YW:0] line_p0;

   logic        vs_rise, vs_fall, two_byte, cap, line_close, pix_done;
   logic        ph_eff, col_ovf, line_ovf, keep;
   logic [XW:0] col_eff;
   logic [15:0] pix_word;

   function automatic logic [15:0] luma_565(input logic [7:0] v);
      return {v[7:3], v[7:2], v[7:3]};
   endfunction

   // Counters saturate at their limit so overflowing lines/pixels stay flagged as dropped.
   function automatic logic [XW:0] inc_col(input logic [XW:0] c);
      return (c < H_LIM) ? c + (XW+1)'(1) : c;
   endfunction

   function automatic logic [YW:0] inc_line(input logic [YW:0] l);
      return (l < V_LIM) ? l + (YW+1)'(1) : l;
   endfunction

   always_comb begin
      vs_rise    = CamVsync & ~vsync_p0;
      vs_fall    = ~CamVsync & vsync_p0;
      two_byte   = (mode_p0 != 2'd2);
      state_nxt  = state;
      cap        = 1'b0;
      line_close = 1'b0;
      // The first byte of a line arrives while still in WAIT_LINE, so phase/column restart there.
      ph_eff     = (state == ACTIVE) ? phase_p0 : 1'b0;
      col_eff    = (state == ACTIVE) ? col_p0 : '0;
      case (state)
         SYNC:      if (vs_fall) state_nxt = WAIT_LINE;
         WAIT_LINE: begin
            if (vs_rise) state_nxt = SYNC;
            else if (CamHsync) begin
               state_nxt = ACTIVE;
               cap       = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise) state_nxt = SYNC;
            else if (CamHsync) cap = 1'b1;
            else begin
               state_nxt  = WAIT_LINE;
               line_close = 1'b1;
            end
         end
         default: state_nxt = SYNC;
      endcase
      pix_done = cap & (~two_byte | ph_eff);
      case (mode_p0)
         2'd1:    pix_word = luma_565(hold_p0);
         2'd2:    pix_word = luma_565(CamData);
         default: pix_word = {hold_p0, CamData};
      endcase
      col_ovf  = (col_eff >= H_LIM);
      line_ovf = (line_p0 >= V_LIM);
      keep     = ~decim_p0 | (~col_eff[0] & ~line_p0[0]);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vsync_p0   <= 1'b0;
         mode_p0    <= 2'd0;
         decim_p0   <= 1'b0;
         phase_p0   <= 1'b0;
         hold_p0    <= 8'd0;
         col_p0     <= '0;
         line_p0    <= '0;
         PixValid   <= 1'b0;
         PixData    <= 16'd0;
         PixX       <= '0;
         PixY       <= '0;
         FrameStart <= 1'b0;
         LineEnd    <= 1'b0;
         FrameDone  <= 1'b0;
         FrameCnt   <= 8'd0;
         Err        <= 2'd0;
      end else begin
         vsync_p0   <= CamVsync;
         PixValid   <= 1'b0;
         FrameStart <= 1'b0;
         LineEnd    <= 1'b0;
         FrameDone  <= 1'b0;
         if (state == SYNC && vs_fall) begin
            FrameStart <= 1'b1;
            mode_p0    <= Mode;
            decim_p0   <= Decim;
            Err        <= 2'd0;
            line_p0    <= '0;
            col_p0     <= '0;
            phase_p0   <= 1'b0;
         end
         if (state != SYNC && vs_rise && line_p0 != '0) begin
            FrameDone <= 1'b1;
            FrameCnt  <= FrameCnt + 8'd1;
         end
         if (cap) begin
            if (!ph_eff) hold_p0 <= CamData;
            phase_p0 <= two_byte & ~ph_eff;
            if (line_ovf) Err[0] <= 1'b1;
            if (pix_done) begin
               col_p0 <= inc_col(col_eff);
               if (col_ovf) Err[0] <= 1'b1;
               else if (!line_ovf && keep) begin
                  PixValid <= 1'b1;
                  PixData  <= pix_word;
                  PixX     <= decim_p0 ? col_eff[XW:1] : col_eff[XW-1:0];
                  PixY     <= decim_p0 ? line_p0[YW:1] : line_p0[YW-1:0];
               end
            end else begin
               col_p0 <= col_eff;
            end
         end
         if (line_close) begin
            phase_p0 <= 1'b0;
            if (two_byte && phase_p0) Err[1] <= 1'b1;
            if (!line_ovf) LineEnd <= 1'b1;
            line_p0 <= inc_line(line_p0);
         end
      end
   end

endmodule

// File: doc/cam_capture_core.md
CAM_CAPTURE_CORE -- requirements
Module: cam_capture_core

Interface
REQ-001 Parameter H_ACTIVE, default 640, maximum pixels accepted per line.
REQ-002 Parameter V_ACTIVE, default 480, maximum lines accepted per frame.
REQ-003 Parameter XW, default 10, width of PixX.
REQ-004 Parameter YW, default 9, width of PixY.
REQ-005 CLK  in  1  sole clock; camera pixel clock domain, all inputs sampled on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 CamVsync  in  1  frame sync, high during vertical blanking.
REQ-008 CamHsync  in  1  line valid (HREF), high while CamData carries active bytes.
REQ-009 CamData  in  8  camera byte stream.
REQ-010 Mode  in  2  format: 0 RGB565, 1 YUYV luma-only, 2 raw8, 3 treated as RGB565.
REQ-011 Decim  in  1  1 = 2x2 decimation.
REQ-012 PixValid  out  1  one-cycle strobe, PixData/PixX/PixY valid.
REQ-013 PixData  out  16  RGB565 pixel.
REQ-014 PixX  out  XW  output column; PixY  out  YW  output row.
REQ-015 FrameStart  out  1  one-cycle pulse at frame start.
REQ-016 LineEnd  out  1  one-cycle pulse at completed line.
REQ-017 FrameDone  out  1  one-cycle pulse at completed frame.
REQ-018 FrameCnt  out  8  completed-frame counter.
REQ-019 Err  out  2  sticky; bit0 overflow, bit1 partial pixel.

Function
REQ-020 FSM states SYNC, WAIT_LINE, ACTIVE; SYNC is the reset state.
REQ-021 SYNC -> WAIT_LINE on CamVsync falling edge (high previous cycle, low this cycle); FrameStart pulses the following cycle; Mode and Decim latched then and held for the whole frame; Err, line count and byte phase cleared.
REQ-022 WAIT_LINE -> ACTIVE when CamHsync high; ACTIVE -> WAIT_LINE when CamHsync low.
REQ-023 Any state -> SYNC when CamVsync rises; if at least one line completed this frame, FrameDone pulses next cycle and FrameCnt increments (wraps 255->0); otherwise neither.
REQ-024 Vsync rising during ACTIVE aborts the line: no LineEnd, partial pixel discarded, Err bit1 not set.
REQ-025 RGB565: first byte of each pair = PixData[15:8], second = PixData[7:0]; pixel complete on second byte.
REQ-026 YUYV: byte phase 0 is Y, phase 1 is chroma (discarded); pixel complete on chroma byte; PixData = {Y[7:3],Y[7:2],Y[7:3]}.
REQ-027 Raw8: every byte a pixel; PixData = {D[7:3],D[7:2],D[7:3]}.
REQ-028 Latency: completing byte sampled in cycle k -> PixValid high in cycle k+1, single cycle; all pixel outputs registered.
REQ-029 Byte phase resets to 0 at every CamHsync rising edge.
REQ-030 Input column counter increments per completed pixel, clears at line start; input line counter increments per completed line.
REQ-031 Decim=0: every pixel emitted, PixX = input column, PixY = input line.
REQ-032 Decim=1: only even column and even line emitted; PixX = column>>1, PixY = line>>1.
REQ-033 Pixels with input column >= H_ACTIVE dropped, Err bit0 set; lines with input line >= V_ACTIVE dropped entirely (no PixValid, no LineEnd), Err bit0 set.
REQ-034 CamHsync falling with byte phase 1 in two-byte mode: pending byte discarded, Err bit1 set.
REQ-035 LineEnd pulses the cycle after CamHsync falls in ACTIVE, even for odd lines under Decim=1; line counter increments simultaneously.
REQ-036 Err bits persist until the next frame start or reset.
REQ-037 PixData/PixX/PixY hold last value when PixValid low.

Reset
REQ-038 RST high: state SYNC, all outputs 0, FrameCnt 0, Err 0, counters 0, latched Mode 0, Decim 0, edge detectors 0.
REQ-039 Reset release mid-frame: no pixels emitted until a CamVsync falling edge is seen.

Verification
REQ-040 Mode 0, H_ACTIVE=4, V_ACTIVE=2, 2 lines bytes 0xF8,0x00 x4 -> 8 PixValid, PixData 0xF800, PixX 0..3, PixY 0..1, 2 LineEnd, FrameDone, FrameCnt 1, Err 0.
REQ-041 Mode 1, line bytes 0x80,0x11,0xFF,0x22 -> two pixels, PixData 0x8410 then 0xFFFF, each one cycle after the chroma byte.
REQ-042 Mode 2, Decim=1, 4x4 frame -> 4 pixels at (0,0),(1,0),(0,1),(1,1), 4 LineEnd.
REQ-043 Mode 0, line of 5 pixels with H_ACTIVE=4 -> 4 pixels, Err=01; line with 3 bytes -> 1 pixel, Err bit1 set; both cleared at next FrameStart.
REQ-044 RST asserted mid-line then released mid-frame -> outputs 0 immediately, no PixValid until next vsync fall; Vsync rising mid-line -> no LineEnd, FrameDone only if prior line completed.
